nif_msg_pool: RTL
=================

Name: nif_msg_pool

Overview:
- Indexed message buffer pool that feeds nif_manager and absorbs its outputs.
- Ingress messages and manager-generated messages (msg8) are each stored in a slot.
- Stored slots are queued in arrival order and presented to the manager as msg4/msg4index/msg4src.
- Each slot stays allocated until it is released by retiredindx or by the downstream forwarder.

Parameters:
DWID, 128, data field width
AWID, 32, address field width
TWID, 5, tag field width
BWID, derived from DWID as in the rou message format (128->4), byte-count width
WID, 2+DWID+AWID+BWID+TWID, full message width
WBUFS, 6, slot index width; all-ones (NOTLEGAL) means "no slot"
SLOTS, 16, number of slots; must satisfy 2 <= SLOTS <= 2^WBUFS-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_msg  in  WID  ingress message
in_src  in  2  ingress source (1=up, 2=down)
in_vld  in  1  ingress valid
in_rdy  out  1  ingress accept; transfer occurs when in_vld&&in_rdy
msg4  out  WID  head message; all-zero when queue empty
msg4index  out  WBUFS  head slot; NOTLEGAL when queue empty
msg4src  out  2  head source; 3 = manager-generated
msg4_ack  in  1  pop head
use2free  in  1  manager requests store of msg8
msg8index  in  WBUFS  target slot for msg8
msg8  in  WID  manager message
msg8_ack  out  1  store done, one-cycle pulse
free2indx  out  WBUFS  slot reserved for the manager; NOTLEGAL if none
retiredindx  in  WBUFS  slot release from the manager; NOTLEGAL = none
rel_indx  in  WBUFS  slot release from the forwarder; NOTLEGAL = none
free_count  out  WBUFS  number of free, unreserved slots
err_dbl_free  out  1  sticky: a free slot was released
err_bad_index  out  1  sticky: msg8index != reserved slot, or out-of-range index

Behaviour:
- Reset: all slots free except slot 0, which becomes the reserved slot.
  - free2indx=0, queue empty, msg4=0, msg4index=NOTLEGAL, msg4src=0.
  - msg8_ack=0, in_rdy=0 during reset, free_count=SLOTS-1, error flags=0.
  - Reset during operation discards all queued and stored messages.
- Free bitmap: one bit per slot. A priority encoder picks the lowest-index free slot, excluding the reserved slot.
- Ingress:
  - in_rdy = (an unreserved free slot exists) && !(use2free && !ack_pending).
  - On transfer: mem[slot]<=in_msg, src[slot]<=in_src, slot marked busy, slot index enqueued. Takes effect on the next edge.
- Manager store:
  - When use2free && !ack_pending && msg8index==reserved: mem[reserved]<=msg8, src<=3, index enqueued, ack_pending<=1.
  - msg8_ack is registered, high the cycle after the store. ack_pending clears when msg8_ack is high.
  - use2free while ack_pending is ignored.
  - A new reserved slot is taken from the lowest free slot in the same edge. If none exists, free2indx=NOTLEGAL until one is released.
  - If msg8index != reserved: no store, no ack, err_bad_index set.
- Queue arbitration:
  - Index FIFO of depth SLOTS with WBUFS-wide pointers wrapping modulo SLOTS. It cannot overflow because every entry owns a slot.
  - One enqueue per cycle. The manager store has priority; ingress is stalled by in_rdy.
- Output:
  - msg4 = mem[head], msg4index = head, msg4src = src[head], all combinational from registered state.
  - msg4_ack with a non-empty queue pops on the edge.
  - msg4_ack with an empty queue is ignored.
  - Latency: ingress accepted at edge T appears on msg4 after edge T when the queue was empty.
- Release:
  - retiredindx and rel_indx are both processed in the same cycle. Each != NOTLEGAL clears its slot's busy bit.
  - Releasing an already-free slot: no state change, err_dbl_free set.
  - If both name the same slot: a single release, no error.
  - A released slot may be allocated in the following cycle, not the same cycle.
  - Releasing a slot still in the queue is legal. The queue entry stays; the slot contents are undefined once reallocated, and this is the caller's responsibility.
- free_count: registered popcount of free, unreserved slots, updated each edge.

Decomposition:
- Shared package (rou_pkg):
  - Parameters: WID/BWID derivation, NOTLEGAL constant.
  - Source codes SRC_UP=1, SRC_DOWN=2, SRC_MNG=3.
  - Message field offsets, shared with rou_msg_fields/rou_msg_build.
- Sub-module: nif_pool_freelist.
  - Contains the bitmap, lowest-free encoder excluding the reserved slot, release logic with double-free detection, and free_count.
  - Top level holds the memory, the index FIFO and the msg8 handshake.

Test Plan:
- Reset release -> free2indx=0, free_count=15, msg4index=63, msg4=0; first in_vld stores to slot 1 and msg4index=1, msg4src=1 next cycle.
- 15 ingress messages without release -> slots 1..15 used, in_rdy=0, free_count=0; retiredindx=5 -> in_rdy=1 next cycle, next ingress goes to slot 5.
- use2free with msg8index=0 and in_vld both high -> in_rdy=0 that cycle, msg8_ack pulses once next cycle, msg4src=3, free2indx moves to lowest free (1), ingress accepted the following cycle.
- Pop order: ingress A, msg8 B, ingress C with msg4_ack held high -> msg4index sequence A, B, C, then 63 with msg4=0.
- retiredindx=3 and rel_indx=3 same cycle -> slot 3 freed once, err_dbl_free=0; later retiredindx=3 again -> err_dbl_free=1 (sticky).
- use2free with msg8index=7 while reserved=0 -> no msg8_ack, err_bad_index=1; rst mid-queue -> queue empty, free2indx=0.

Source files
------------

// File: rtl/rou_pkg.sv
// Shared message-format definitions for the rou/nif pool blocks.
// Field layout, source codes and slot index helpers.
package rou_pkg;

  localparam int DWID  = 128;
  localparam int AWID  = 32;
  localparam int TWID  = 5;
  localparam int BWID  = $clog2(DWID / 8);
  localparam int WID   = 2 + DWID + AWID + BWID + TWID;
  localparam int WBUFS = 6;
  localparam int SLOTS = 16;
  localparam int SW    = $clog2(SLOTS);

  localparam int OFF_TAG  = 0;
  localparam int OFF_BCNT = OFF_TAG + TWID;
  localparam int OFF_ADDR = OFF_BCNT + BWID;
  localparam int OFF_DATA = OFF_ADDR + AWID;
  localparam int OFF_CMD  = OFF_DATA + DWID;

  typedef logic [WID-1:0]   msg_t;
  typedef logic [WBUFS-1:0] idx_t;

  localparam idx_t NOTLEGAL = '1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_UP   = 2'd1,
    SRC_DOWN = 2'd2,
    SRC_MNG  = 2'd3
  } src_e;

  function automatic idx_t wrap_inc(idx_t p);
    return (p == idx_t'(SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/nif_msg_pool_if.sv
// Handshake bundle between the message pool and its users.
// master = producer/manager side, slave = pool.
interface nif_msg_pool_if;
  import rou_pkg::*;

  msg_t       in_msg;
  logic [1:0] in_src;
  logic       in_vld;
  logic       in_rdy;
  msg_t       msg4;
  idx_t       msg4index;
  logic [1:0] msg4src;
  logic       msg4_ack;
  logic       use2free;
  idx_t       msg8index;
  msg_t       msg8;
  logic       msg8_ack;
  idx_t       free2indx;
  idx_t       retiredindx;
  idx_t       rel_indx;
  idx_t       free_count;
  logic       err_dbl_free;
  logic       err_bad_index;

  modport master (
    output in_msg, in_src, in_vld, msg4_ack,
    output use2free, msg8index, msg8,
    output retiredindx, rel_indx,
    input  in_rdy, msg4, msg4index, msg4src,
    input  msg8_ack, free2indx, free_count,
    input  err_dbl_free, err_bad_index
  );

  modport slave (
    input  in_msg, in_src, in_vld, msg4_ack,
    input  use2free, msg8index, msg8,
    input  retiredindx, rel_indx,
    output in_rdy, msg4, msg4index, msg4src,
    output msg8_ack, free2indx, free_count,
    output err_dbl_free, err_bad_index
  );

endinterface

// File: rtl/nif_pool_freelist.sv
// Slot free bitmap, lowest-free picker, manager reservation
// and release handling with double-free detection.
module nif_pool_freelist import rou_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic i_alloc,
  input  logic i_store,
  input  idx_t i_rel_a,
  input  idx_t i_rel_b,
  output idx_t o_low,
  output logic o_any,
  output idx_t o_rsv,
  output idx_t o_free_count,
  output logic o_err_dbl,
  output logic o_rel_rng
);

  localparam logic [SLOTS-1:0] FREE_RST =
    {{(SLOTS-1){1'b1}}, 1'b0};

  logic [SLOTS-1:0] r_free;
  idx_t             r_rsv;
  idx_t             r_cnt;
  logic             r_dbl;

  idx_t             w_low;
  logic             w_any;
  logic [SLOTS-1:0] w_rel;
  logic             w_dbl;
  logic             w_rng;
  logic [SLOTS-1:0] w_nxt;
  idx_t             w_rsv_nxt;
  idx_t             w_cnt;

  // lowest-index free slot; reserved slot is never marked free
  always_comb begin
    w_low = NOTLEGAL;
    w_any = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (r_free[i]) begin
        w_low = idx_t'(i);
        w_any = 1'b1;
      end
    end
  end

  // decode both release ports against the current bitmap
  always_comb begin
    w_rel = '0;
    w_dbl = 1'b0;
    w_rng = 1'b0;
    if (i_rel_a != NOTLEGAL) begin
      if (int'(i_rel_a) >= SLOTS) w_rng = 1'b1;
      else if (r_free[i_rel_a[SW-1:0]] || i_rel_a == r_rsv)
        w_dbl = 1'b1;
      else w_rel[i_rel_a[SW-1:0]] = 1'b1;
    end
    if (i_rel_b != NOTLEGAL) begin
      if (int'(i_rel_b) >= SLOTS) w_rng = 1'b1;
      else if (r_free[i_rel_b[SW-1:0]] || i_rel_b == r_rsv)
        w_dbl = 1'b1;
      else w_rel[i_rel_b[SW-1:0]] = 1'b1;
    end
  end

  // next bitmap and reservation; refill of a missing
  // reservation takes the free slot ahead of ingress
  always_comb begin
    w_nxt     = r_free | w_rel;
    w_rsv_nxt = r_rsv;
    if (i_store || r_rsv == NOTLEGAL) begin
      w_rsv_nxt = w_low;
      if (w_any) w_nxt[w_low[SW-1:0]] = 1'b0;
    end else if (i_alloc && w_any) begin
      w_nxt[w_low[SW-1:0]] = 1'b0;
    end
  end

  // popcount of the next bitmap
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < SLOTS; i++)
      w_cnt = w_cnt + {{(WBUFS-1){1'b0}}, w_nxt[i]};
  end

  // bitmap, reservation, count and sticky error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free <= FREE_RST;
      r_rsv  <= '0;
      r_cnt  <= idx_t'(SLOTS - 1);
      r_dbl  <= 1'b0;
    end else begin
      r_free <= w_nxt;
      r_rsv  <= w_rsv_nxt;
      r_cnt  <= w_cnt;
      if (w_dbl) r_dbl <= 1'b1;
    end
  end

  assign o_low        = w_low;
  assign o_any        = w_any;
  assign o_rsv        = r_rsv;
  assign o_free_count = r_cnt;
  assign o_err_dbl    = r_dbl;
  assign o_rel_rng    = w_rng;

endmodule

// File: rtl/nif_msg_pool.sv
// Indexed message pool: slot storage, arrival-order index
// queue and the manager msg8 store handshake.
module nif_msg_pool import rou_pkg::*; (
  input logic           clk,
  input logic           rst,
  nif_msg_pool_if.slave bus
);

  msg_t       r_mem [SLOTS];
  logic [1:0] r_src [SLOTS];
  idx_t       r_q   [SLOTS];
  idx_t       r_head;
  idx_t       r_tail;
  idx_t       r_cnt;
  logic       r_pend;
  logic       r_ack;
  logic       r_bad;

  idx_t w_low;
  logic w_any;
  idx_t w_rsv;
  logic w_rng;
  logic w_rdy;
  logic w_store;
  logic w_bad;
  logic w_take;
  logic w_push;
  idx_t w_push_idx;
  logic w_empty;
  logic w_pop;
  idx_t w_head;

  assign w_rdy = !rst && w_any && (w_rsv != NOTLEGAL)
              && !(bus.use2free && !r_pend);
  assign w_store = bus.use2free && !r_pend
                && (w_rsv != NOTLEGAL)
                && (bus.msg8index == w_rsv);
  assign w_bad      = bus.use2free && !r_pend && !w_store;
  assign w_take     = bus.in_vld && w_rdy;
  assign w_push     = w_store || w_take;
  assign w_push_idx = w_store ? w_rsv : w_low;
  assign w_empty    = (r_cnt == '0);
  assign w_pop      = bus.msg4_ack && !w_empty;
  assign w_head     = r_q[r_head[SW-1:0]];

  nif_pool_freelist u_free (
    .clk          (clk),
    .rst          (rst),
    .i_alloc      (w_take),
    .i_store      (w_store),
    .i_rel_a      (bus.retiredindx),
    .i_rel_b      (bus.rel_indx),
    .o_low        (w_low),
    .o_any        (w_any),
    .o_rsv        (w_rsv),
    .o_free_count (bus.free_count),
    .o_err_dbl    (bus.err_dbl_free),
    .o_rel_rng    (w_rng)
  );

  // slot payload; manager message wins the single write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_push_idx[SW-1:0]] <=
        w_store ? bus.msg8 : bus.in_msg;
      r_src[w_push_idx[SW-1:0]] <=
        w_store ? SRC_MNG : bus.in_src;
    end
  end

  // index queue storage
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_tail[SW-1:0]] <= w_push_idx;
  end

  // queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_tail <= wrap_inc(r_tail);
      if (w_pop)  r_head <= wrap_inc(r_head);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // msg8 ack pulse, pending guard and bad-index flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_ack  <= 1'b0;
      r_bad  <= 1'b0;
    end else begin
      r_ack <= w_store;
      if (w_store)    r_pend <= 1'b1;
      else if (r_ack) r_pend <= 1'b0;
      if (w_bad || w_rng) r_bad <= 1'b1;
    end
  end

  assign bus.in_rdy        = w_rdy;
  assign bus.msg4          = w_empty ? '0 : r_mem[w_head[SW-1:0]];
  assign bus.msg4index     = w_empty ? NOTLEGAL : w_head;
  assign bus.msg4src       = w_empty ? 2'd0 : r_src[w_head[SW-1:0]];
  assign bus.msg8_ack      = r_ack;
  assign bus.free2indx     = w_rsv;
  assign bus.err_bad_index = r_bad;

endmodule
